// File: rtl/z80_vram_pkg.sv
// Shared widths and encodings for the Z80 video RAM arbiter.
package z80_vram_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT_SLOT,
        RD_DATA,
        RD_DONE
    } rd_state_e;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

endpackage

// File: rtl/z80_vram_wbuf.sv
// One-entry CPU write buffer: accepts a write when empty or draining, drains on
// any cycle the video port leaves free, and flags address hits for forwarding.
module z80_vram_wbuf
    import z80_vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic              vld_o,
    output logic              accept_o,
    output logic              drain_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic [DATA_W-1:0] drain_data_o,
    output logic              hit_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign drain_o      = vld_q && !vid_req_i;
    assign accept_o     = wr_i && (!vld_q || drain_o);
    assign hit_o        = vld_q && (addr_q == cmp_addr_i);
    assign vld_o        = vld_q;
    assign drain_addr_o = addr_q;
    assign drain_data_o = data_q;

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        if (accept_o) begin
            vld_d  = 1'b1;
            addr_d = addr_i;
            data_d = wdata_i;
        end else if (drain_o) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/z80_vram_arbiter.sv
// Single-port VRAM arbiter: video reads first, then write drain, then CPU reads.
// Define Z80_VRAM_WBUF_EN to add the one-entry write buffer with read forwarding.
module z80_vram_arbiter
    import z80_vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    rd_state_e         state_q, state_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              rd_vld_q, rd_vld_d;
    owner_e            owner_q, owner_d;

    logic              rd_act, slot_free, cpu_issue;
    logic              buf_vld, buf_hit, buf_drain, wr_accept;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    // A simultaneous write wins; the read is not seen until cpu_we drops.
    assign rd_act = cpu_rd && !cpu_we;

`ifdef Z80_VRAM_WBUF_EN
    z80_vram_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_i         (cpu_we),
        .addr_i       (cpu_addr),
        .wdata_i      (cpu_wdata),
        .vid_req_i    (vid_req),
        .cmp_addr_i   (cpu_addr),
        .vld_o        (buf_vld),
        .accept_o     (wr_accept),
        .drain_o      (buf_drain),
        .drain_addr_o (buf_addr),
        .drain_data_o (buf_data),
        .hit_o        (buf_hit)
    );
`else
    // Unbuffered: the write itself takes the drain slot as soon as video is idle.
    assign buf_vld   = 1'b0;
    assign buf_hit   = 1'b0;
    assign buf_drain = cpu_we && !vid_req;
    assign wr_accept = buf_drain;
    assign buf_addr  = cpu_addr;
    assign buf_data  = cpu_wdata;
`endif

    assign slot_free = !vid_req && !buf_vld;

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_issue   = 1'b0;
        if (rd_vld_q && owner_q == OWN_CPU) cpu_rdata_d = ram_rdata;
        case (state_q)
            RD_IDLE, RD_WAIT_SLOT: begin
                if (!rd_act) begin
                    state_d = RD_IDLE;
                end else if (buf_hit) begin
                    state_d     = RD_DONE;
                    cpu_rdata_d = buf_data;
                end else if (slot_free) begin
                    state_d   = RD_DATA;
                    cpu_issue = 1'b1;
                end else begin
                    state_d = RD_WAIT_SLOT;
                end
            end
            RD_DATA: state_d = RD_DONE;
            RD_DONE: if (!cpu_rd) state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // Owner tag follows each granted read so the returning byte lands in the right register.
    always_comb begin
        rd_vld_d   = vid_req || cpu_issue;
        owner_d    = vid_req ? OWN_VID : OWN_CPU;
        vid_data_d = (rd_vld_q && owner_q == OWN_VID) ? ram_rdata : vid_data_q;
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        cpu_wait  = 1'b0;
        if (reset_n) begin
            if (vid_req) begin
                ram_addr = vid_addr;
            end else if (buf_drain) begin
                ram_addr  = buf_addr;
                ram_wdata = buf_data;
                ram_we    = 1'b1;
            end else if (cpu_issue) begin
                ram_addr = cpu_addr;
            end
            if (cpu_we) cpu_wait = !wr_accept;
            else        cpu_wait = (state_q == RD_DATA) || (cpu_rd && state_q != RD_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RD_IDLE;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            rd_vld_q    <= 1'b0;
            owner_q     <= OWN_VID;
        end else begin
            state_q     <= state_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            rd_vld_q    <= rd_vld_d;
            owner_q     <= owner_d;
        end
    end

    assign vid_data  = vid_data_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_z80_vram_arbiter.sv
// Randomised bench for z80_vram_arbiter against a RAM model and a CPU-view shadow memory.
module tb_z80_vram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_rd, cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_wait;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    z80_vram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_val(input int a);
        if (a == 32'h1800) return 8'hA5;
        if (a == 32'h0123) return 8'h3C;
        return 8'((a * 13) ^ (a >> 5) ^ 8'h5A);
    endfunction

    // Synchronous-read RAM model; also logs every write address in order.
    logic [7:0]  mem [0:8191];
    bit          mem_ready = 1'b0;
    logic [12:0] wlog [$];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wlog.push_back(ram_addr);
            end
        end
    end

    typedef struct { int due; logic [7:0] data; } vexp_t;
    vexp_t      vq [$];
    logic [7:0] shadow [0:8191];
    int         total = 0;
    int         bad = 0;
    bit         vid_hold = 1'b0;
    bit         vid_rand = 1'b0;
    int         vid_burst = 0;
    int         vid_fix = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called once per cycle at the falling edge: retire due video checks, then drive the video port.
    task automatic vid_step();
        bit          go;
        logic [12:0] a;
        while (vq.size() > 0 && vq[0].due <= cyc) begin
            chk("vid_data", vid_data, vq[0].data);
            void'(vq.pop_front());
        end
        go = vid_hold || (vid_burst > 0) || (vid_rand && $urandom_range(0, 7) < 2);
        if (vid_burst > 0) vid_burst--;
        a = (vid_fix >= 0) ? 13'(vid_fix) : 13'($urandom);
        vid_req  = go;
        vid_addr = a;
        if (go) vq.push_back('{due: cyc + 2, data: mem[a]});
    endtask

    task automatic next_cycle();
        @(negedge clk);
        vid_step();
    endtask

    task automatic cpu_read(input logic [12:0] a, output int lat, output int lead);
        logic [7:0] exp;
        bit         done, free;
        next_cycle();
        cpu_rd = 1'b1; cpu_addr = a;
        exp = shadow[a];
        lat = 0; lead = 0; done = 1'b0; free = 1'b0;
        while (!done && lat < 64) begin
            #1;
            if (!free) begin
                if (vid_req) lead++;
                else         free = 1'b1;
            end
            if (!cpu_wait) done = 1'b1;
            else begin
                lat++;
                next_cycle();
            end
        end
        if (!done) chk("rd_done", 32'(done), 1);
        else begin
            chk("rd_data", cpu_rdata, exp);
            next_cycle();
            #1;
            chk("rd_hold_wait", cpu_wait, 0);
            chk("rd_hold_data", cpu_rdata, exp);
        end
        next_cycle();
        cpu_rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d, output int lat, output int lead);
        bit done, free;
        next_cycle();
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        lat = 0; lead = 0; done = 1'b0; free = 1'b0;
        while (!done && lat < 64) begin
            #1;
            if (!free) begin
                if (vid_req) lead++;
                else         free = 1'b1;
            end
            if (!cpu_wait) done = 1'b1;
            else begin
                lat++;
                next_cycle();
            end
        end
        if (!done) chk("wr_done", 32'(done), 1);
        else       shadow[a] = d;
        next_cycle();
        cpu_we = 1'b0;
    endtask

    task automatic do_reset(input int n);
        vid_hold = 1'b0; vid_rand = 1'b0; vid_burst = 0;
        vq.delete();
        vid_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_wait", cpu_wait, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_vid", vid_data, 0);
        chk("rst_rdata", cpu_rdata, 0);
        repeat (n) next_cycle();
        cpu_rd = 1'b0; cpu_we = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        int          lat, lead, w0, nerr;
        logic [7:0]  old;
        logic [12:0] a;
        for (int i = 0; i < 8192; i++) shadow[i] = init_val(i);

        // Reset with every request input active: all outputs must read zero.
        reset_n = 1'b0; cpu_rd = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0ABC; cpu_wdata = 8'h55;
        vid_req = 1'b1; vid_addr = 13'h1234;
        #1;
        chk("init_vid", vid_data, 0);
        chk("init_rdata", cpu_rdata, 0);
        chk("init_wait", cpu_wait, 0);
        chk("init_we", ram_we, 0);
        chk("init_addr", ram_addr, 0);
        chk("init_wdata", ram_wdata, 0);
        cpu_rd = 1'b0; cpu_we = 1'b0;
        repeat (2) next_cycle();
        reset_n = 1'b1;
        repeat (2) next_cycle();

        // Video read of 0x1800 colliding with a CPU read of 0x0000.
        vid_fix = 32'h1800; vid_burst = 1;
        cpu_read(13'h0000, lat, lead);
        chk("vidcol_lat", lat, 3);
        vid_fix = -1;

        cpu_read(13'h0123, lat, lead);
        chk("unloaded_lat", lat, 2);
        chk("unloaded_val", shadow[13'h0123], 8'h3C);

        vid_burst = 2;
        cpu_read(13'h0456, lat, lead);
        chk("collide_lat", lat, 4);

        w0 = wlog.size();
`ifdef Z80_VRAM_WBUF_EN
        vid_burst = 12;
        cpu_write(13'h0040, 8'h77, lat, lead);
        chk("wb_first_lat", lat, 0);
        cpu_read(13'h0040, lat, lead);
        chk("fwd_lat", lat, 1);
        cpu_write(13'h0041, 8'h88, lat, lead);
        chk("wb_second_lat", lat, 6);
`else
        vid_burst = 3;
        cpu_write(13'h0040, 8'h77, lat, lead);
        chk("wr_stall_lat", lat, 3);
        cpu_read(13'h0040, lat, lead);
        chk("rd_after_wr_lat", lat, 2);
        cpu_write(13'h0041, 8'h88, lat, lead);
        chk("wr_free_lat", lat, 0);
`endif
        repeat (3) next_cycle();
        chk("wlog_count", wlog.size() - w0, 2);
        if (wlog.size() - w0 == 2) begin
            chk("wlog_first", wlog[w0], 13'h0040);
            chk("wlog_second", wlog[w0 + 1], 13'h0041);
        end

        // Reset while the CPU read sits in DATA; afterwards a fresh read completes normally.
        next_cycle();
        cpu_rd = 1'b1; cpu_addr = 13'h0200;
        next_cycle();
        #1;
        chk("pre_rst_wait", cpu_wait, 1);
        do_reset(2);
        next_cycle();
        cpu_read(13'h0200, lat, lead);
        chk("post_rst_lat", lat, 2);

`ifdef Z80_VRAM_WBUF_EN
        vid_hold = 1'b1;
        old = shadow[13'h0300];
        cpu_write(13'h0300, ~old, lat, lead);
        chk("discard_acc_lat", lat, 0);
        do_reset(2);
        shadow[13'h0300] = old;
        next_cycle();
        cpu_read(13'h0300, lat, lead);
        chk("discard_rd_lat", lat, 2);
`endif

        vid_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                cpu_write(a, 8'($urandom), lat, lead);
`ifndef Z80_VRAM_WBUF_EN
                chk("rand_wr_lat", lat, lead);
`endif
            end else begin
                cpu_read(a, lat, lead);
`ifndef Z80_VRAM_WBUF_EN
                chk("rand_rd_lat", lat, lead + 2);
`endif
            end
        end
        vid_rand = 1'b0;
        repeat (4) next_cycle();

        nerr = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== shadow[i]) nerr++;
        chk("mem_final", nerr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/z80_vram_arbiter.md
Name: z80_vram_arbiter

Overview:
- Single-port video RAM arbiter, directly upstream of the video scan-out stage.
- Shares one 8 KiB synchronous-read RAM between the video fetch port (fixed-slot pixel/attribute reads) and the Z80 CPU bus.
- Video reads have absolute priority; CPU accesses are absorbed by a one-entry write buffer or stalled via a WAIT output.

Parameters:
- ADDR_W, 13, RAM/video/CPU address width (8 KiB window).
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, 25 MHz pixel clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  one-cycle video read strobe.
- vid_addr  in  ADDR_W  video read address, qualified by vid_req.
- vid_data  out  DATA_W  registered video read data; holds until the next video read returns.
- cpu_rd  in  1  CPU read request (level), held until completion.
- cpu_we  in  1  CPU write request (level).
- cpu_addr  in  ADDR_W  CPU address (0x0000 = first VRAM byte).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, valid in DONE.
- cpu_wait  out  1  high = the presented access has not completed this cycle.
- ram_addr  out  ADDR_W  RAM address (combinational from grant).
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, one cycle after address.

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE; write buffer emptied and any pending write discarded; vid_data=0, cpu_rdata=0, cpu_wait=0, ram_we=0, ram_addr=0, ram_wdata=0. This applies mid-operation too: an in-flight read is dropped and no completion is produced.
- Per-cycle grant priority: vid_req > buffered write drain > CPU read issue. Exactly one RAM access per cycle.
- Video path:
  - vid_req at cycle t drives ram_addr=vid_addr, ram_we=0.
  - ram_rdata is valid at t+1 and is registered into vid_data, visible from t+2.
  - Latency is fixed at 2 and is independent of CPU traffic.
  - A 1-bit owner pipeline tags each granted read (video or CPU) so returning data is steered correctly.
- Write buffer (one entry: addr, data, valid):
  - cpu_we while the buffer is empty, or being drained this cycle, is accepted that cycle with cpu_wait=0.
  - cpu_we while the buffer is full and not draining gives cpu_wait=1 until it is accepted.
  - The entry drains (ram_we=1) in any cycle without vid_req.
- cpu_we and cpu_rd both high: the write is serviced and the read is ignored.
- Read FSM:
  - IDLE:
    - cpu_rd and cpu_addr matches valid buffer addr → DONE next cycle with cpu_rdata=buffered data (forwarding).
    - Otherwise, if the grant is won this cycle → DATA; if not → WAIT_SLOT.
    - cpu_wait=1 in IDLE while cpu_rd is high.
  - WAIT_SLOT: cpu_wait=1. Moves to DATA in the first cycle with no vid_req and an empty buffer. Forwarding is re-checked every cycle.
  - DATA: cpu_wait=1; ram_rdata is captured into cpu_rdata → DONE.
  - DONE: cpu_wait=0, cpu_rdata stable. Stays until cpu_rd=0, then → IDLE. This prevents double issue.
  - Unloaded read: request at t, cpu_wait high at t and t+1, data valid with cpu_wait=0 at t+2.
  - Worst case with vid_req at most 2 per 16 cycles: 5 cycles.
- A video read to an address held in the write buffer returns the RAM (old) contents. Video coherence is not guaranteed before drain.
- All addresses wrap modulo 2^ADDR_W. No out-of-range decode inside the block.

Optional Feature:
- Macro: Z80_VRAM_WBUF_EN.
- Defined: write buffer and read forwarding as described above.
- Undefined: no buffer. A write follows the read path timing: it issues at the first cycle without vid_req, and cpu_wait stays high until that cycle. Forwarding logic is absent.

Decomposition:
- Package z80_vram_pkg:
  - ADDR_W/DATA_W defaults.
  - Read FSM state enum (IDLE, WAIT_SLOT, DATA, DONE).
  - Grant-owner encoding (OWN_VID, OWN_CPU).
- Sub-module z80_vram_wbuf: one-entry buffer providing accept, drain, address-compare hit and forward data. Instantiated only under Z80_VRAM_WBUF_EN.

Test Plan:
- Video latency: vid_req at t with addr 0x1800, RAM[0x1800]=0xA5 → vid_data=0xA5 at t+2; concurrent cpu_rd to 0x0000 does not alter that.
- Unloaded CPU read: cpu_rd to 0x0123 (RAM=0x3C), no vid_req → cpu_wait 1,1,0 and cpu_rdata=0x3C at t+2; stays in DONE until cpu_rd drops.
- Collision: cpu_rd at t and vid_req at t and t+1 → CPU grant at t+2, cpu_rdata valid at t+4, vid_data correct at t+2/t+3.
- Write buffer: cpu_we 0x0040←0x77 with vid_req held → accepted with cpu_wait=0; a second write sees cpu_wait=1 until the first drains; ram_we pulses in order.
- Forwarding: write 0x0040←0x77 still buffered, then cpu_rd 0x0040 → DONE next cycle with rdata=0x77 and no RAM read.
- Reset mid-read: assert reset_n=0 in DATA → cpu_wait=0, buffer empty, ram_we=0 immediately; after release FSM is IDLE and the first read completes normally.
